// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external combinational ALU, with a registered
// valid/ready result stage. One command per cycle when the output is not stalled.
`timescale 1ns/1ps

package alu_pkg;
  localparam int N = 8;
endpackage

module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [2:0]               alu_opcode,
  input  logic [N-1:0]             alu_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_y,
  output logic [2:0]               out_opcode,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [2:0]    op_mem_q [DEPTH];
  logic [N-1:0]  a_mem_q  [DEPTH];
  logic [N-1:0]  b_mem_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_y_q, out_y_d;
  logic [2:0]    out_op_q, out_op_d;

  logic          empty;
  logic          push;
  logic          pop;

  // in_ready comes only from registered level, never from out_ready.
  assign in_ready = (level_q != FULL);
  assign empty    = (level_q == '0);

  assign alu_a      = empty ? '0 : a_mem_q[rd_ptr_q];
  assign alu_b      = empty ? '0 : b_mem_q[rd_ptr_q];
  assign alu_opcode = empty ? '0 : op_mem_q[rd_ptr_q];

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_opcode = out_op_q;
  assign level      = level_q;

  always_comb begin
    push = in_valid && in_ready;
    pop  = !empty && (!out_valid_q || out_ready);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end

    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_op_d    = out_op_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      out_op_d    = op_mem_q[rd_ptr_q];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q] <= in_opcode;
      a_mem_q[wr_ptr_q]  <= in_a;
      b_mem_q[wr_ptr_q]  <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_op_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_op_q    <= out_op_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: bench-side ALU, scoreboard of expected
// results, immediate-assertion checks.
`timescale 1ns/1ps

module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_opcode;
  logic [N-1:0]   in_a, in_b;
  logic [N-1:0]   alu_a, alu_b, alu_y;
  logic [2:0]     alu_opcode;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_y;
  logic [2:0]     out_opcode;
  logic [$clog2(DEPTH):0] level;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   res_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_level = 1'b0;
  bit   rnd_ready = 1'b0;
  logic [N-1:0] held_y;
  logic [N-1:0] exp_stream [8] = '{8'h2C, 8'hB4, 8'hEF, 8'hF1, 8'h0F, 8'h30, 8'hFC, 8'hCC};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_opcode(out_opcode), .level(level)
  );

  function automatic logic [N-1:0] ref_alu(input logic [2:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a - 8'd1;
      3'd3:    return a + 8'd1;
      3'd4:    return ~a;
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_y = ref_alu(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 99) >= 40);
  endtask

  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] ey);
    int t = 0;
    exp_t e;
    e.op = op;
    e.y  = ey;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        step();
        break;
      end
      t++;
      if (t > 200) begin
        chk("send_timeout", t, 0);
        break;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb.size() != 0 || out_valid) begin
      step();
      t++;
      if (t > 300) begin
        chk(tag, sb.size(), 0);
        break;
      end
    end
  endtask

  // Result monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("out_y", out_y, mon_e.y);
          chk("out_opcode", out_opcode, mon_e.op);
          res_cyc.push_back(cyc);
        end
      end
      if (chk_level) chk("level_max", level <= 4, 1);
    end
  end

  initial begin
    logic [2:0]   rop;
    logic [N-1:0] ra, rb;
    in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    rst_n = 1'b1;
    step();

    // single command
    send(3'd0, 8'h0F, 8'h01, 8'h10);
    chk("t1_level_accept", level, 1);
    chk("t1_head_a", alu_a, 8'h0F);
    chk("t1_head_b", alu_b, 8'h01);
    chk("t1_valid_early", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_out_y", out_y, 8'h10);
    chk("t1_level_after", level, 0);
    wait_drain("t1_drain");

    // all opcodes back to back
    res_cyc.delete();
    for (int i = 0; i < 8; i++) send(i[2:0], 8'hF0, 8'h3C, exp_stream[i]);
    wait_drain("t2_drain");
    chk("t2_count", res_cyc.size(), 8);
    for (int i = 1; i < res_cyc.size(); i++) chk("t2_no_bubble", res_cyc[i] - res_cyc[i-1], 1);

    // backpressure: 5 held, sixth refused
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(3'(i + 1), 8'h20 + 8'(i), 8'h03, ref_alu(3'(i + 1), 8'h20 + 8'(i), 8'h03));
    chk("t3_level_full", level, 4);
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    held_y = out_y;
    in_valid = 1'b1; in_opcode = 3'd6; in_a = 8'h55; in_b = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_ready", in_ready, 0);
      chk("t3_stall_level", level, 4);
      chk("t3_out_y_stable", out_y, held_y);
    end

    // pop from full: not ready this cycle, then push+pop keeps level
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_full_pop_ready", in_ready, 0);
    step();
    chk("t4_level_drop", level, 3);
    @(negedge clk);
    chk("t4_ready_again", in_ready, 1);
    sb.push_back('{op: 3'd6, y: ref_alu(3'd6, 8'h55, 8'h0A)});
    step();
    chk("t4_level_pushpop", level, 3);
    in_valid = 1'b0;
    wait_drain("t3_drain");
    chk("t3_in_ready_end", in_ready, 1);
    chk("t3_level_end", level, 0);

    // push+pop at level 2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd7, 8'h81 + 8'(i), 8'hFF, ref_alu(3'd7, 8'h81 + 8'(i), 8'hFF));
    chk("t4_level2", level, 2);
    out_ready = 1'b1;
    send(3'd1, 8'h10, 8'h20, 8'hF0);
    chk("t4_level2_hold", level, 2);
    wait_drain("t4_drain");

    // wrap-around under random backpressure
    rnd_ready = 1'b1;
    chk_level = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      send(rop, ra, rb, ref_alu(rop, ra, rb));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain("t5_drain");
    chk_level = 1'b0;

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd0, 8'(i), 8'h01, 8'(i + 1));
    chk("t6_level_pre", level, 3);
    chk("t6_valid_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_out_y", out_y, 0);
    chk("t6_rst_level", level, 0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send(3'd5, 8'hAA, 8'h0F, 8'h0A);
    wait_drain("t6_drain");
    chk("t6_level_end", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
